// File: rtl/writeback_stack_pkg.sv
// writeback_stack_pkg
//   Shared definitions for the stack write-back stage and its fetch-stage
//   counterpart.
//   - Default address and data widths.
//   - Stack word offsets. They fix where each top-of-stack word sits
//     relative to the stack pointer.
//   - The handshake state encoding.
//   - A small helper that detects the last word of a request.
package writeback_stack_pkg;

  localparam int ADDRESS_BITS = 8;
  localparam int DATA_BITS    = 16;

  // Word k of the top of stack lives at stackPointer + k.
  // The fetch stage uses the same layout.
  localparam int TOS1_OFFSET = 0;
  localparam int TOS2_OFFSET = 1;
  localparam int TOS3_OFFSET = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wbState_t;

  // True when idx addresses the final word of a request with 'count' words.
  // Only meaningful for count >= 1, which is guaranteed whenever WRITE is entered.
  function automatic logic isLastWord(input logic [1:0] idx, input logic [1:0] count);
    logic [1:0] lastIdx;
    lastIdx = count - 2'd1;
    return idx == lastIdx;
  endfunction

endpackage

// File: rtl/writeback_stack_word_select.sv
// stack_word_select
//   Combinational 3:1 selector.
//   It picks one of the three top-of-stack words by its word index.
//   The fetch stage's offset logic can reuse it.
// Ports
//   idx          in   2         word index (0..2)
//   topOfStack1  in   dataBits  word at offset TOS1_OFFSET
//   topOfStack2  in   dataBits  word at offset TOS2_OFFSET
//   topOfStack3  in   dataBits  word at offset TOS3_OFFSET
//   word         out  dataBits  selected word
module stack_word_select
  import writeback_stack_pkg::*;
#(
  parameter int dataBits = DATA_BITS
) (
  input  logic [1:0]          idx,
  input  logic [dataBits-1:0] topOfStack1,
  input  logic [dataBits-1:0] topOfStack2,
  input  logic [dataBits-1:0] topOfStack3,
  output logic [dataBits-1:0] word
);

  // Index 3 never occurs for a legal request.
  // Word 0 is used for it so that the mux stays fully specified.
  always_comb begin
    word = topOfStack1;
    case (idx)
      2'(TOS1_OFFSET): word = topOfStack1;
      2'(TOS2_OFFSET): word = topOfStack2;
      2'(TOS3_OFFSET): word = topOfStack3;
      default:         word = topOfStack1;
    endcase
  end

endmodule

// File: rtl/writeback_stack.sv
// writeback_stack
//   Writes up to three top-of-stack words back to stack memory.
//   Word k is written to stackPointer + k, which is the layout the fetch
//   stage reads.
//   A start/finished handshake sequences each request.
//   Every memory write takes two cycles. The address and data are set up in
//   phase 0, and the write strobe is asserted in phase 1.
// Ports
//   clk           in   1         clock, all state changes on posedge
//   reset         in   1         synchronous, active-low reset
//   start         in   1         request a write-back (honoured in IDLE/DONE only)
//   count         in   2         number of words to write, 0..3
//   stackPointer  in   addrBits  base address
//   topOfStack1   in   dataBits  word 0
//   topOfStack2   in   dataBits  word 1
//   topOfStack3   in   dataBits  word 2
//   address       out  addrBits  memory address
//   dataIn        out  dataBits  memory write data
//   writeEnable   out  1         memory write strobe
//   busy          out  1         high while writing
//   finished      out  1         high (level) once the request has completed
module writeback_stack
  import writeback_stack_pkg::*;
#(
  parameter int addrBits = ADDRESS_BITS,
  parameter int dataBits = DATA_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          count,
  input  logic [addrBits-1:0] stackPointer,
  input  logic [dataBits-1:0] topOfStack1,
  input  logic [dataBits-1:0] topOfStack2,
  input  logic [dataBits-1:0] topOfStack3,
  output logic [addrBits-1:0] address,
  output logic [dataBits-1:0] dataIn,
  output logic                writeEnable,
  output logic                busy,
  output logic                finished
);

  wbState_t            state;
  wbState_t            nextState;
  logic [1:0]          idx;
  logic [1:0]          nextIdx;
  logic                phase;
  logic                nextPhase;
  logic                loadSnap;

  logic [1:0]          snapCount;
  logic [addrBits-1:0] snapSP;
  logic [dataBits-1:0] snapTop1;
  logic [dataBits-1:0] snapTop2;
  logic [dataBits-1:0] snapTop3;
  logic [dataBits-1:0] selWord;

  // The request is captured when it is accepted.
  // From then on the outputs depend only on this snapshot, so the execute
  // stage may change its inputs immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      phase     <= 1'b0;
      snapCount <= 2'd0;
      snapSP    <= '0;
      snapTop1  <= '0;
      snapTop2  <= '0;
      snapTop3  <= '0;
    end else begin
      state <= nextState;
      idx   <= nextIdx;
      phase <= nextPhase;
      if (loadSnap) begin
        snapCount <= count;
        snapSP    <= stackPointer;
        snapTop1  <= topOfStack1;
        snapTop2  <= topOfStack2;
        snapTop3  <= topOfStack3;
      end
    end
  end

  // DONE accepts a new start exactly as IDLE does.
  // This lets requests run back to back without a gap cycle.
  // A start seen during WRITE is dropped.
  always_comb begin
    nextState = state;
    nextIdx   = idx;
    nextPhase = phase;
    loadSnap  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          loadSnap  = 1'b1;
          nextIdx   = 2'd0;
          nextPhase = 1'b0;
          nextState = (count == 2'd0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (!phase) begin
          nextPhase = 1'b1;
        end else if (isLastWord(idx, snapCount)) begin
          nextState = DONE;
          nextIdx   = 2'd0;
          nextPhase = 1'b0;
        end else begin
          nextIdx   = idx + 2'd1;
          nextPhase = 1'b0;
        end
      end
      default: begin
        nextState = IDLE;
        nextIdx   = 2'd0;
        nextPhase = 1'b0;
      end
    endcase
  end

  stack_word_select #(
    .dataBits(dataBits)
  ) wordSelect (
    .idx        (idx),
    .topOfStack1(snapTop1),
    .topOfStack2(snapTop2),
    .topOfStack3(snapTop3),
    .word       (selWord)
  );

  // The address sum is truncated to addrBits.
  // A stack that straddles the top of memory therefore wraps to address 0.
  always_comb begin
    busy        = (state == WRITE);
    finished    = (state == DONE);
    writeEnable = busy && phase;
    address     = snapSP;
    dataIn      = snapTop1;
    if (busy) begin
      address = snapSP + addrBits'(idx);
      dataIn  = selWord;
    end
  end

endmodule

// File: tb/tb_writeback_stack.sv
// tb_writeback_stack
//   Self-checking bench for writeback_stack.
//   The stimulus tasks push the expected memory writes into a queue.
//   A separate monitor pops one entry per write strobe, checks it, and
//   updates a small memory model.
module tb_writeback_stack;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    count;
  logic [AW-1:0] stackPointer;
  logic [DW-1:0] topOfStack1;
  logic [DW-1:0] topOfStack2;
  logic [DW-1:0] topOfStack3;
  logic [AW-1:0] address;
  logic [DW-1:0] dataIn;
  logic          writeEnable;
  logic          busy;
  logic          finished;

  int  checks      = 0;
  int  errors      = 0;
  int  strobeCount = 0;
  int  baseStrobes = 0;
  wr_t expQ[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  writeback_stack #(
    .addrBits(AW),
    .dataBits(DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .stackPointer(stackPointer),
    .topOfStack1 (topOfStack1),
    .topOfStack2 (topOfStack2),
    .topOfStack3 (topOfStack3),
    .address     (address),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .busy        (busy),
    .finished    (finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // The monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    wr_t e;
    if (writeEnable === 1'b1) begin
      strobeCount++;
      mem[address] = dataIn;
      checkOutput("strobeBusy", busy, 1);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedStrobe: got write %0h@%0h, expected no write", dataIn, address);
      end else begin
        e = expQ.pop_front();
        if (address !== e.addr || dataIn !== e.data) begin
          errors++;
          $display("[TB] FAIL writeMatch: got %0h@%0h, expected %0h@%0h", dataIn, address, e.data, e.addr);
        end
      end
    end
  end

  // Issue a request. Called away from the rising edge.
  // The inputs are scrambled right after acceptance to prove that the
  // snapshot is what gets written.
  task automatic applyStimulus(input logic [1:0] cnt, input logic [AW-1:0] sp,
                               input logic [DW-1:0] t1, input logic [DW-1:0] t2,
                               input logic [DW-1:0] t3);
    wr_t e;
    count        = cnt;
    stackPointer = sp;
    topOfStack1  = t1;
    topOfStack2  = t2;
    topOfStack3  = t3;
    start        = 1'b1;
    for (int k = 0; k < int'(cnt); k++) begin
      e.addr = sp + AW'(k);
      e.data = (k == 0) ? t1 : (k == 1) ? t2 : t3;
      expQ.push_back(e);
    end
    baseStrobes = strobeCount;
    @(posedge clk);
    #1;
    start        = 1'b0;
    count        = ~cnt;
    stackPointer = ~sp;
    topOfStack1  = ~t1;
    topOfStack2  = ~t2;
    topOfStack3  = ~t3;
  endtask

  // n counts the edges after the accepting edge.
  // finished must appear exactly at n == 2*cnt.
  task automatic waitFinished(input string name, input int cnt, input bit midPulse);
    int n;
    n = 0;
    @(negedge clk);
    checkOutput({name, "BusyFirst"}, busy, (cnt != 0));
    while (finished !== 1'b1 && n < 40) begin
      if (midPulse && n == 2) begin
        start        = 1'b1;
        stackPointer = 8'hEE;
        topOfStack1  = 16'hDEAD;
        topOfStack2  = 16'hBEEF;
        topOfStack3  = 16'hF00D;
      end
      if (midPulse && n == 3) start = 1'b0;
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput({name, "Latency"}, n, 2 * cnt);
    checkOutput({name, "Finished"}, finished, 1);
    checkOutput({name, "BusyDone"}, busy, 0);
    checkOutput({name, "Strobes"}, strobeCount - baseStrobes, cnt);
    checkOutput({name, "Pending"}, expQ.size(), 0);
  endtask

  initial begin
    int k;
    int held;
    reset        = 1'b0;
    start        = 1'b1;
    count        = 2'd3;
    stackPointer = 8'h55;
    topOfStack1  = 16'h1234;
    topOfStack2  = 16'h5678;
    topOfStack3  = 16'h9ABC;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstAddress", address, 0);
    checkOutput("rstDataIn", dataIn, 0);
    checkOutput("rstWriteEnable", writeEnable, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFinished", finished, 0);
    checkOutput("rstStrobes", strobeCount, 0);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idleFinished", finished, 0);

    $display("[TB] basic write, count=3 at 0x10");
    applyStimulus(2'd3, 8'h10, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    waitFinished("basic", 3, 1'b0);
    checkOutput("mem10", mem[8'h10], 16'hAAAA);
    checkOutput("mem11", mem[8'h11], 16'hBBBB);
    checkOutput("mem12", mem[8'h12], 16'hCCCC);

    $display("[TB] count=0, back to back from DONE");
    applyStimulus(2'd0, 8'h30, 16'h0101, 16'h0202, 16'h0303);
    waitFinished("count0", 0, 1'b0);

    $display("[TB] count=1");
    applyStimulus(2'd1, 8'h34, 16'h1111, 16'h2222, 16'h3333);
    waitFinished("count1", 1, 1'b0);
    checkOutput("mem34", mem[8'h34], 16'h1111);

    $display("[TB] count=2, back to back");
    applyStimulus(2'd2, 8'h38, 16'h4444, 16'h5555, 16'h6666);
    waitFinished("count2", 2, 1'b0);

    $display("[TB] wrap-around at top of memory");
    applyStimulus(2'd3, 8'hFF, 16'h7777, 16'h8888, 16'h9999);
    waitFinished("wrap", 3, 1'b0);
    checkOutput("memFF", mem[8'hFF], 16'h7777);
    checkOutput("mem00", mem[8'h00], 16'h8888);
    checkOutput("mem01", mem[8'h01], 16'h9999);

    $display("[TB] input change and start pulse during WRITE");
    applyStimulus(2'd3, 8'h40, 16'hA1A1, 16'hB2B2, 16'hC3C3);
    waitFinished("midStart", 3, 1'b1);
    checkOutput("memEEuntouched", (mem[8'hEE] === 16'hDEAD), 0);

    $display("[TB] reset after first strobe");
    applyStimulus(2'd3, 8'h20, 16'h2020, 16'h2121, 16'h2222);
    k = 0;
    while (strobeCount == baseStrobes && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("rstMidFirstStrobe", strobeCount - baseStrobes, 1);
    reset = 1'b0;
    expQ.delete();
    held = strobeCount;
    repeat (2) @(negedge clk);
    checkOutput("rstMidAddress", address, 0);
    checkOutput("rstMidDataIn", dataIn, 0);
    checkOutput("rstMidBusy", busy, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("rstMidNoStrobes", strobeCount - held, 0);
    checkOutput("rstMidIdle", finished, 0);

    $display("[TB] normal request after reset");
    applyStimulus(2'd2, 8'h60, 16'h6060, 16'h6161, 16'h6262);
    waitFinished("postRst", 2, 1'b0);
    checkOutput("mem61", mem[8'h61], 16'h6161);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
